vga_scanout: RTL and testbench

- Framebuffer read side: the rasterizer writes 4-bit pixels at linear address y*640+x; this block reads them back in raster order and drives the VGA output.
- Generates 640x480@60 timing from a pixel-clock enable and issues pipelined reads to frame memory.
- Aligns hsync/vsync/blank with the returning read data.
- Optionally writes zero behind the beam so the next frame starts blank, and manages double-buffer swap at vblank.

---
 rtl/vga_pkg.sv | 15 +
 rtl/vga_timing.sv | 42 ++++
 rtl/vga_scanout.sv | 79 +++++++
 tb/tb_vga_scanout.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants and framebuffer geometry shared by the scanout blocks
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FB_PIXELS = H_ACTIVE * V_ACTIVE;
  localparam int ADDR_W = 19;
endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixEn-gated raster counters; outputs active, in-sync flags (hs/vs, active high), frame_start and frame_wrap
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP = vga_pkg::H_FP,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BP = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP = vga_pkg::V_FP,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BP = vga_pkg::V_BP
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pixEn,
  output logic active,
  output logic hs,
  output logic vs,
  output logic frame_start,
  output logic frame_wrap
);
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  logic [9:0] hcnt, vcnt;
  logic h_end, v_end;
  assign h_end = hcnt == 10'(HT - 1);
  assign v_end = vcnt == 10'(VT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pixEn) begin
      hcnt <= h_end ? '0 : hcnt + 10'd1;
      if (h_end) vcnt <= v_end ? '0 : vcnt + 10'd1;
    end
  assign active = hcnt < 10'(H_ACTIVE) && vcnt < 10'(V_ACTIVE);
  assign hs = hcnt >= 10'(H_ACTIVE + H_FP) && hcnt < 10'(H_ACTIVE + H_FP + H_SYNC);
  assign vs = vcnt >= 10'(V_ACTIVE + V_FP) && vcnt < 10'(V_ACTIVE + V_FP + V_SYNC);
  assign frame_start = pixEn && hcnt == '0 && vcnt == 10'(V_ACTIVE);
  assign frame_wrap = h_end && v_end;
endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: framebuffer scanout; pipelined reads (rdEn/rdAddr/rdData), clear-behind-beam (clrWe/clrAddr), buffer swap (bufSel/swapReq/swapAck), VGA out
module vga_scanout
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP = vga_pkg::H_FP,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BP = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP = vga_pkg::V_FP,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BP = vga_pkg::V_BP,
  parameter int RD_LATENCY = 2,
  parameter bit CLEAR_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pixEn,
  output logic              rdEn,
  output logic [ADDR_W-1:0] rdAddr,
  input  logic [3:0]        rdData,
  output logic              clrWe,
  output logic [ADDR_W-1:0] clrAddr,
  output logic              bufSel,
  input  logic              swapReq,
  output logic              swapAck,
  output logic [3:0]        vgaColor,
  output logic              hsync,
  output logic              vsync,
  output logic              blank,
  output logic              frameStart
);
  localparam int L = RD_LATENCY;
  logic active, hs, vs, frame_wrap, swap_pend, take;
  logic [ADDR_W-1:0] addr;
  logic [L-1:0] act_d, hs_d, vs_d;
  logic [L*ADDR_W-1:0] addr_d;
  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk(clk), .rst_n(rst_n), .pixEn(pixEn), .active(active), .hs(hs), .vs(vs),
    .frame_start(frameStart), .frame_wrap(frame_wrap)
  );
  // counters sit at (0,0) during reset, which decodes as active; rst_n keeps the strobe quiet
  assign rdEn = pixEn & active & rst_n;
  assign rdAddr = addr;
  assign take = frameStart & swap_pend;
  assign swapAck = take;
  // the write lands on the tick its read data returns, so it never overtakes a pending read
  assign clrWe = CLEAR_EN && pixEn && act_d[L-1];
  assign clrAddr = addr_d[L*ADDR_W-1 -: ADDR_W];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr <= '0;
      act_d <= '0;
      hs_d <= '0;
      vs_d <= '0;
      addr_d <= '0;
      vgaColor <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      blank <= 1'b1;
      bufSel <= 1'b0;
      swap_pend <= 1'b0;
    end else if (pixEn) begin
      addr <= frame_wrap ? '0 : addr + ADDR_W'(active);
      act_d <= L'({act_d, active});
      hs_d <= L'({hs_d, hs});
      vs_d <= L'({vs_d, vs});
      addr_d <= (L*ADDR_W)'({addr_d, addr});
      vgaColor <= act_d[L-1] ? rdData : 4'h0;
      blank <= ~act_d[L-1];
      hsync <= ~hs_d[L-1];
      vsync <= ~vs_d[L-1];
      bufSel <= bufSel ^ take;
      swap_pend <= take ? 1'b0 : swap_pend | swapReq;
    end
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed checks of a full-timing and a reduced-timing vga_scanout
module tb_vga_scanout;
  logic clk = 1'b0, rst_n = 1'b0, pixEn = 1'b0, swapReq = 1'b0, fill = 1'b0;
  always #5 clk = ~clk;
  logic f_rdEn, f_clrWe, f_bufSel, f_swapAck, f_hsync, f_vsync, f_blank, f_frameStart;
  logic [18:0] f_rdAddr, f_clrAddr;
  logic [3:0] f_rdData, f_vgaColor;
  logic s_rdEn, s_clrWe, s_bufSel, s_swapAck, s_hsync, s_vsync, s_blank, s_frameStart;
  logic [18:0] s_rdAddr, s_clrAddr;
  logic [3:0] s_rdData, s_vgaColor;
  int total = 0, bad = 0, tk = 0, div = 1;
  logic [7:0] snap;
  vga_scanout #(.CLEAR_EN(1'b0)) dut_f (
    .clk(clk), .rst_n(rst_n), .pixEn(pixEn), .rdEn(f_rdEn), .rdAddr(f_rdAddr), .rdData(f_rdData),
    .clrWe(f_clrWe), .clrAddr(f_clrAddr), .bufSel(f_bufSel), .swapReq(swapReq), .swapAck(f_swapAck),
    .vgaColor(f_vgaColor), .hsync(f_hsync), .vsync(f_vsync), .blank(f_blank), .frameStart(f_frameStart)
  );
  vga_scanout #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .RD_LATENCY(2), .CLEAR_EN(1'b1)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .pixEn(pixEn), .rdEn(s_rdEn), .rdAddr(s_rdAddr), .rdData(s_rdData),
    .clrWe(s_clrWe), .clrAddr(s_clrAddr), .bufSel(s_bufSel), .swapReq(swapReq), .swapAck(s_swapAck),
    .vgaColor(s_vgaColor), .hsync(s_hsync), .vsync(s_vsync), .blank(s_blank), .frameStart(s_frameStart)
  );
  logic [3:0] mem [32];
  logic [3:0] s_p0, s_p1, f_p0, f_p1;
  always @(posedge clk) begin
    if (fill) for (int i = 0; i < 32; i++) mem[i] <= 4'hF;
    else if (s_clrWe) mem[s_clrAddr[4:0]] <= 4'h0;
    if (pixEn) begin
      s_p0 <= mem[s_rdAddr[4:0]];
      s_p1 <= s_p0;
      f_p0 <= f_rdAddr[3:0];
      f_p1 <= f_p0;
    end
  end
  assign s_rdData = s_p1;
  assign f_rdData = f_p1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic pre();
    pixEn = 1'b1;
    #1;
  endtask
  task automatic post();
    @(posedge clk);
    #1;
    pixEn = 1'b0;
    tk++;
    snap = {s_vgaColor, s_hsync, s_vsync, s_blank, s_bufSel};
    repeat (div - 1) begin
      @(posedge clk);
      #1;
      chk("idle_hold", {s_vgaColor, s_hsync, s_vsync, s_blank, s_bufSel}, snap);
      chk("idle_strobes", {s_rdEn, s_clrWe, s_swapAck, s_frameStart}, 0);
    end
  endtask
  task automatic run_to(input int n);
    while (tk < n) begin
      pre();
      post();
    end
  endtask
  initial begin
    pixEn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdEn", {f_rdEn, s_rdEn}, 0);
    chk("rst_strobes", {f_clrWe, s_clrWe, f_swapAck, s_swapAck, f_frameStart, s_frameStart}, 0);
    chk("rst_sync", {f_hsync, f_vsync, f_blank, s_hsync, s_vsync, s_blank}, 6'h3f);
    chk("rst_color", {f_vgaColor, s_vgaColor}, 0);
    chk("rst_buf", {f_bufSel, s_bufSel}, 0);
    pixEn = 1'b0;
    rst_n = 1'b1;
    pre(); chk("f_addr0", {f_rdEn, f_rdAddr}, {1'b1, 19'd0}); post();
    run_to(2); chk("f_blank_lat", f_blank, 1);
    run_to(3); chk("f_first_pix", {f_blank, f_vgaColor}, 0);
    run_to(5); pre(); chk("f_addr5", f_rdAddr, 5); chk("f_noclear", f_clrWe, 0); post();
    run_to(8); chk("f_pix5", f_vgaColor, 5);
    run_to(640); pre(); chk("f_hblank_rd", f_rdEn, 0); post();
    run_to(642); chk("f_pix639", {f_blank, f_vgaColor}, 5'h0f);
    run_to(643); chk("f_blank_end", {f_blank, f_vgaColor}, 5'h10);
    run_to(658); chk("f_hs_pre", f_hsync, 1);
    run_to(659); chk("f_hs_fall", f_hsync, 0);
    run_to(754); chk("f_hs_last", f_hsync, 0);
    run_to(755); chk("f_hs_rise", f_hsync, 1);
    run_to(800); pre(); chk("f_addr640", {f_rdEn, f_rdAddr}, {1'b1, 19'd640}); post();
    run_to(811); chk("f_pix648", {f_blank, f_vgaColor}, 5'h08);
    rst_n = 1'b0;
    fill = 1'b1;
    #1;
    chk("f_rst_async", {f_blank, f_vgaColor}, 5'h10);
    @(posedge clk); #1; fill = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1; tk = 0;
    pre(); chk("s_addr0", {s_rdAddr, s_clrWe}, 0); post();
    pre(); chk("s_noclr1", s_clrWe, 0); post();
    pre(); chk("s_clr0", {s_clrWe, s_clrAddr}, {1'b1, 19'd0}); post();
    run_to(3); chk("s_f1_first", {s_blank, s_vgaColor}, 5'h0f);
    run_to(55); pre(); chk("s_last_addr", {s_rdEn, s_rdAddr}, {1'b1, 19'd31}); post();
    pre(); chk("s_vblank_rd", s_rdEn, 0); post();
    pre(); chk("s_clr_last", {s_clrWe, s_clrAddr}, {1'b1, 19'd31}); post();
    chk("s_f1_last", {s_blank, s_vgaColor}, 5'h0f);
    pre(); chk("s_clr_off", s_clrWe, 0); post();
    chk("s_blank_on", s_blank, 1);
    run_to(63); pre(); chk("s_fs_pre", s_frameStart, 0); post();
    pre(); chk("s_fs", {s_frameStart, s_swapAck}, 2'b10); post();
    chk("s_noswap", s_bufSel, 0);
    run_to(82); chk("s_vs_pre", s_vsync, 1);
    run_to(83); chk("s_vs_fall", s_vsync, 0);
    run_to(114); chk("s_vs_last", s_vsync, 0);
    run_to(115); chk("s_vs_rise", s_vsync, 1);
    run_to(131); chk("s_f2_first", {s_blank, s_vgaColor}, 0);
    run_to(140); swapReq = 1'b1;
    run_to(150); swapReq = 1'b0;
    run_to(186); chk("s_f2_last", {s_blank, s_vgaColor}, 0);
    run_to(191); pre(); chk("s_ack_pre", s_swapAck, 0); post();
    pre(); chk("s_ack", {s_frameStart, s_swapAck, s_bufSel}, 3'b110); post();
    chk("s_buf_tog", s_bufSel, 1);
    pre(); chk("s_ack_once", s_swapAck, 0); post();
    div = 4;
    run_to(319); pre(); chk("s4_fs_pre", s_frameStart, 0); post();
    pre(); chk("s4_fs", {s_frameStart, s_swapAck}, 2'b10); post();
    chk("s4_buf_hold", s_bufSel, 1);
    run_to(348); chk("s4_hs_pre", s_hsync, 1);
    run_to(349); chk("s4_hs_fall", {s_hsync, s_vsync}, 0);
    rst_n = 1'b0;
    #1;
    chk("s_rst_async", {s_hsync, s_vsync, s_blank, s_bufSel}, 4'b1110);
    @(posedge clk); #1; rst_n = 1'b1; tk = 0;
    pre(); chk("s_rst_addr0", {s_rdEn, s_rdAddr}, {1'b1, 19'd0}); chk("f_rst_addr0", f_rdAddr, 0); post();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
